bitrev_out: RTL and testbench

BITREV_OUT -- requirements
Module: bitrev_out

---
 rtl/bitrev_out.sv | 223 ++++++++++++++++++++++
 tb/tb_bitrev_out.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bitrev_out.sv
// bitrev_out: unloads an FFT result RAM in natural order.
// The RAM holds the frame in bit-reversed order. The block walks a natural-order
// index, reads the RAM at the bit-reversed address, and re-times the returned
// data (2-cycle RAM latency) so that it lines up with its index and frame markers.
module bitrev_out #(
   parameter int ADDR_WIDTH = 12,
   parameter int DATA_WIDTH = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic                  abort,
   input  logic [3:0]            log2_n,
   output logic                  rd_en,
   output logic [ADDR_WIDTH-1:0] rd_addr,
   input  logic [DATA_WIDTH-1:0] rd_re,
   input  logic [DATA_WIDTH-1:0] rd_im,
   output logic                  out_valid,
   output logic [DATA_WIDTH-1:0] out_re,
   output logic [DATA_WIDTH-1:0] out_im,
   output logic [ADDR_WIDTH-1:0] out_index,
   output logic                  out_sop,
   output logic                  out_eop,
   output logic                  busy,
   output logic                  done
);

   // Width able to hold any size exponent from 0 up to ADDR_WIDTH.
   localparam int NLW = $clog2(ADDR_WIDTH + 1);

   // Stage 0 and 1 cover the RAM latency; the last stage is the output register.
   localparam int PIPE_DEPTH = 3;
   localparam int OUT_STAGE  = PIPE_DEPTH - 1;

   // DRAIN lasts as many cycles as it takes the last read to reach the output.
   localparam logic [1:0] DRAIN_LAST = 2'(PIPE_DEPTH - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t state;
   state_t state_next;

   // Frame configuration and natural-order read index.
   logic [NLW-1:0]        n_log;
   logic [NLW-1:0]        n_log_clamped;
   logic [ADDR_WIDTH-1:0] idx;
   logic [ADDR_WIDTH-1:0] last_idx;
   logic                  is_last;
   logic [1:0]            drain_cnt;

   // Bit-reversal datapath.
   logic [ADDR_WIDTH-1:0] idx_rev_full;
   logic [NLW-1:0]        rev_shift;

   // Alignment pipeline carrying {valid, idx, sop, eop} alongside the RAM data.
   logic [PIPE_DEPTH-1:0] pipe_valid;
   logic [PIPE_DEPTH-1:0] pipe_sop;
   logic [PIPE_DEPTH-1:0] pipe_eop;
   logic [ADDR_WIDTH-1:0] pipe_idx [PIPE_DEPTH];

   // ------------------------------------------------------------------
   // Size handling
   // ------------------------------------------------------------------

   // Clamp the requested exponent into the range the RAM can address.
   always_comb begin
      if (log2_n < 4'd2) begin
         n_log_clamped = NLW'(2);
      end else if (int'(log2_n) > ADDR_WIDTH) begin
         n_log_clamped = NLW'(ADDR_WIDTH);
      end else begin
         n_log_clamped = NLW'(log2_n);
      end
   end

   // 2^n_log - 1; for n_log == ADDR_WIDTH the shift wraps to 0 and the
   // subtraction wraps to all ones, which is exactly the last index.
   assign last_idx = (ADDR_WIDTH'(1) << n_log) - ADDR_WIDTH'(1);
   assign is_last  = (idx == last_idx);

   // ------------------------------------------------------------------
   // Bit-reversed read address
   // ------------------------------------------------------------------

   // Full-width mirror of the index. Since idx < 2^n_log, shifting the mirror
   // right by (ADDR_WIDTH - n_log) gives the n_log-bit reversal with every
   // bit at or above n_log forced to zero.
   generate
      for (genvar gi = 0; gi < ADDR_WIDTH; gi++) begin : g_rev
         assign idx_rev_full[gi] = idx[ADDR_WIDTH-1-gi];
      end
   endgenerate

   assign rev_shift = NLW'(ADDR_WIDTH) - n_log;
   assign rd_addr   = rd_en ? (idx_rev_full >> rev_shift) : '0;

   // ------------------------------------------------------------------
   // Control FSM
   // ------------------------------------------------------------------

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic; abort has priority over everything, including start.
   always_comb begin
      state_next = state;
      if (abort) begin
         state_next = IDLE;
      end else begin
         case (state)
            IDLE:    if (start)                   state_next = READ;
            READ:    if (is_last)                 state_next = DRAIN;
            DRAIN:   if (drain_cnt == DRAIN_LAST) state_next = DONE;
            DONE:                                 state_next = IDLE;
            default:                              state_next = IDLE;
         endcase
      end
   end

   // State-decoded outputs.
   always_comb begin
      rd_en = (state == READ);
      busy  = (state != IDLE);
      done  = (state == DONE);
   end

   // Index, size latch and drain counter. Start is only honoured in IDLE.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx       <= '0;
         n_log     <= '0;
         drain_cnt <= '0;
      end else if (abort) begin
         idx       <= '0;
         drain_cnt <= '0;
      end else begin
         case (state)
            IDLE: begin
               drain_cnt <= '0;
               if (start) begin
                  n_log <= n_log_clamped;
                  idx   <= '0;
               end
            end
            READ: begin
               drain_cnt <= '0;
               idx       <= is_last ? '0 : idx + ADDR_WIDTH'(1);
            end
            DRAIN: begin
               drain_cnt <= drain_cnt + 2'd1;
            end
            default: begin
               drain_cnt <= '0;
            end
         endcase
      end
   end

   // ------------------------------------------------------------------
   // Output alignment pipeline
   // ------------------------------------------------------------------

   // Shift the read tags along with the RAM latency; the output stage only
   // loads on a valid sample so data, index and markers hold between samples.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pipe_valid <= '0;
         pipe_sop   <= '0;
         pipe_eop   <= '0;
         for (int i = 0; i < PIPE_DEPTH; i++) begin
            pipe_idx[i] <= '0;
         end
         out_re <= '0;
         out_im <= '0;
      end else if (abort) begin
         pipe_valid <= '0;
         pipe_sop   <= '0;
         pipe_eop   <= '0;
      end else begin
         // Tag the read issued this cycle.
         pipe_valid[0] <= rd_en;
         pipe_idx[0]   <= idx;
         pipe_sop[0]   <= rd_en && (idx == '0);
         pipe_eop[0]   <= rd_en && is_last;

         // Intermediate stages just follow the RAM latency.
         for (int i = 1; i < OUT_STAGE; i++) begin
            pipe_valid[i] <= pipe_valid[i-1];
            pipe_idx[i]   <= pipe_idx[i-1];
            pipe_sop[i]   <= pipe_sop[i-1];
            pipe_eop[i]   <= pipe_eop[i-1];
         end

         // Output stage: RAM data for the tag in the previous stage is on
         // rd_re/rd_im now, so capture both together.
         pipe_valid[OUT_STAGE] <= pipe_valid[OUT_STAGE-1];
         if (pipe_valid[OUT_STAGE-1]) begin
            pipe_idx[OUT_STAGE] <= pipe_idx[OUT_STAGE-1];
            pipe_sop[OUT_STAGE] <= pipe_sop[OUT_STAGE-1];
            pipe_eop[OUT_STAGE] <= pipe_eop[OUT_STAGE-1];
            out_re              <= rd_re;
            out_im              <= rd_im;
         end
      end
   end

   assign out_valid = pipe_valid[OUT_STAGE];
   assign out_index = pipe_idx[OUT_STAGE];
   assign out_sop   = pipe_sop[OUT_STAGE];
   assign out_eop   = pipe_eop[OUT_STAGE];

endmodule

// File: tb/tb_bitrev_out.sv
// Testbench for bitrev_out: a 2-cycle-latency RAM model preloaded with known
// words, plus address and sample scoreboards filled from an independent
// bit-reversal model when each frame is started.
`timescale 1ns/1ps
module tb_bitrev_out;
   localparam int AW = 12;
   localparam int DW = 16;

   logic          clk    = 1'b0;
   logic          rst_n  = 1'b0;
   logic          start  = 1'b0;
   logic          abort  = 1'b0;
   logic [3:0]    log2_n = 4'd0;
   logic          rd_en;
   logic [AW-1:0] rd_addr;
   logic [DW-1:0] rd_re;
   logic [DW-1:0] rd_im;
   logic [DW-1:0] ram_re_s1;
   logic [DW-1:0] ram_im_s1;
   logic          out_valid;
   logic [DW-1:0] out_re;
   logic [DW-1:0] out_im;
   logic [AW-1:0] out_index;
   logic          out_sop;
   logic          out_eop;
   logic          busy;
   logic          done;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      int            idx;
      logic [DW-1:0] re;
      logic [DW-1:0] im;
   } exp_t;

   int   addr_q[$];
   exp_t out_q[$];

   logic [DW-1:0] mem_re [0:(1<<AW)-1];
   logic [DW-1:0] mem_im [0:(1<<AW)-1];

   bitrev_out #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .abort     (abort),
      .log2_n    (log2_n),
      .rd_en     (rd_en),
      .rd_addr   (rd_addr),
      .rd_re     (rd_re),
      .rd_im     (rd_im),
      .out_valid (out_valid),
      .out_re    (out_re),
      .out_im    (out_im),
      .out_index (out_index),
      .out_sop   (out_sop),
      .out_eop   (out_eop),
      .busy      (busy),
      .done      (done)
   );

   always #5 clk = ~clk;

   // RAM with 2-cycle read latency.
   always @(posedge clk) begin
      ram_re_s1 <= mem_re[rd_addr];
      ram_im_s1 <= mem_im[rd_addr];
      rd_re     <= ram_re_s1;
      rd_im     <= ram_im_s1;
   end

   // Reference bit reversal over nb bits, bit by bit.
   function automatic int bitrev_model(input int v, input int nb);
      int r;
      r = 0;
      for (int b = 0; b < nb; b++) begin
         if (((v >> b) & 1) != 0) r = r | (1 << (nb - 1 - b));
      end
      return r;
   endfunction

   task automatic test_reset();
      repeat (3) @(negedge clk);
      n_checks++;
      if ({rd_en, rd_addr, out_valid, out_re, out_im, out_index, out_sop, out_eop, busy, done} !== '0) begin
         n_fail++;
         $display("FAIL reset_state: rd_en=%b rd_addr=%0d out_valid=%b busy=%b done=%b, required all 0",
                  rd_en, rd_addr, out_valid, busy, done);
      end
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      n_checks++;
      if (busy !== 1'b0 || rd_en !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_idle: busy=%b rd_en=%b, required 0 0", busy, rd_en);
      end
      $display("reset: outputs cleared, idle after release");
   endtask

   // One full frame: l2 is driven, nb is the effective exponent. Optional
   // start pokes in READ (cycle 3) and in the DONE cycle; tail is the number
   // of idle cycles checked after done.
   task automatic test_frame(input logic [3:0] l2, input int nb, input bit poke_read,
                             input bit poke_done, input int tail);
      int   n;
      int   n_rd;
      int   n_out;
      int   a;
      exp_t e;
      n     = 1 << nb;
      n_rd  = 0;
      n_out = 0;
      addr_q.delete();
      out_q.delete();
      for (int i = 0; i < n; i++) begin
         a = bitrev_model(i, nb);
         addr_q.push_back(a);
         e.idx = i;
         e.re  = mem_re[a];
         e.im  = mem_im[a];
         out_q.push_back(e);
      end
      @(negedge clk);
      log2_n = l2;
      start  = 1'b1;
      for (int cyc = 1; cyc <= n + 4 + tail; cyc++) begin
         @(negedge clk);
         start  = (poke_read && cyc == 3) || (poke_done && cyc == n + 4);
         log2_n = 4'd5;
         n_checks++;
         if (rd_en !== (cyc <= n)) begin
            n_fail++;
            $display("FAIL rd_en cyc=%0d: got %b, required %b", cyc, rd_en, (cyc <= n));
         end
         if (rd_en === 1'b1) begin
            n_checks++;
            if (addr_q.size() == 0) begin
               n_fail++;
               $display("FAIL rd_extra cyc=%0d: got read of %0d, required none", cyc, rd_addr);
            end else begin
               a = addr_q.pop_front();
               n_rd++;
               if (rd_addr !== AW'(a)) begin
                  n_fail++;
                  $display("FAIL rd_addr cyc=%0d: got %0d, required %0d", cyc, rd_addr, a);
               end
            end
         end else begin
            n_checks++;
            if (rd_addr !== '0) begin
               n_fail++;
               $display("FAIL rd_addr_idle cyc=%0d: got %0d, required 0", cyc, rd_addr);
            end
         end
         n_checks++;
         if (out_valid !== (cyc >= 4 && cyc <= n + 3)) begin
            n_fail++;
            $display("FAIL out_valid cyc=%0d: got %b, required %b", cyc, out_valid, (cyc >= 4 && cyc <= n + 3));
         end
         if (out_valid === 1'b1) begin
            n_checks++;
            if (out_q.size() == 0) begin
               n_fail++;
               $display("FAIL out_extra cyc=%0d: got index %0d, required no sample", cyc, out_index);
            end else begin
               e = out_q.pop_front();
               n_out++;
               if (out_index !== AW'(e.idx) || out_re !== e.re || out_im !== e.im ||
                   out_sop !== (e.idx == 0) || out_eop !== (e.idx == n - 1)) begin
                  n_fail++;
                  $display("FAIL out_sample cyc=%0d: got idx=%0d re=%h im=%h sop=%b eop=%b, required idx=%0d re=%h im=%h sop=%b eop=%b",
                           cyc, out_index, out_re, out_im, out_sop, out_eop,
                           e.idx, e.re, e.im, (e.idx == 0), (e.idx == n - 1));
               end
            end
         end
         n_checks++;
         if (done !== (cyc == n + 4)) begin
            n_fail++;
            $display("FAIL done cyc=%0d: got %b, required %b", cyc, done, (cyc == n + 4));
         end
         n_checks++;
         if (busy !== (cyc <= n + 4)) begin
            n_fail++;
            $display("FAIL busy cyc=%0d: got %b, required %b", cyc, busy, (cyc <= n + 4));
         end
      end
      start = 1'b0;
      n_checks++;
      if (n_rd != n || n_out != n) begin
         n_fail++;
         $display("FAIL frame_count log2_n=%0d: got %0d reads %0d samples, required %0d each", l2, n_rd, n_out, n);
      end
      $display("frame log2_n=%0d (n=%0d): %0d reads, %0d samples", l2, n, n_rd, n_out);
   endtask

   task automatic test_order();
      test_frame(4'd3, 3, 1'b0, 1'b0, 2);
   endtask

   task automatic test_large();
      test_frame(4'd12, 12, 1'b0, 1'b0, 2);
   endtask

   task automatic test_clamp();
      test_frame(4'd0, 2, 1'b0, 1'b0, 2);
      test_frame(4'd15, 12, 1'b0, 1'b0, 2);
   endtask

   task automatic test_abort();
      @(negedge clk);
      log2_n = 4'd4;
      start  = 1'b1;
      for (int cyc = 1; cyc <= 10; cyc++) begin
         @(negedge clk);
         start = 1'b0;
         abort = (cyc == 5);
         if (cyc == 5) begin
            n_checks++;
            if (out_valid !== 1'b1 || rd_en !== 1'b1) begin
               n_fail++;
               $display("FAIL abort_pre: out_valid=%b rd_en=%b, required 1 1", out_valid, rd_en);
            end
         end
         if (cyc >= 6) begin
            n_checks++;
            if (out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || out_eop !== 1'b0 || rd_en !== 1'b0) begin
               n_fail++;
               $display("FAIL abort_post cyc=%0d: out_valid=%b busy=%b done=%b eop=%b rd_en=%b, required all 0",
                        cyc, out_valid, busy, done, out_eop, rd_en);
            end
         end
      end
      abort = 1'b0;
      $display("abort: frame cancelled on 5th read cycle");
      test_frame(4'd4, 4, 1'b0, 1'b0, 2);
   endtask

   task automatic test_async_reset();
      @(negedge clk);
      log2_n = 4'd3;
      start  = 1'b1;
      for (int cyc = 1; cyc <= 6; cyc++) begin
         @(negedge clk);
         start = 1'b0;
      end
      n_checks++;
      if (out_valid !== 1'b1 || out_index !== AW'(2) || busy !== 1'b1) begin
         n_fail++;
         $display("FAIL areset_pre: out_valid=%b out_index=%0d busy=%b, required 1 2 1", out_valid, out_index, busy);
      end
      #2 rst_n = 1'b0;
      #1;
      n_checks++;
      if ({rd_en, rd_addr, out_valid, out_re, out_im, out_index, out_sop, out_eop, busy, done} !== '0) begin
         n_fail++;
         $display("FAIL areset_async: rd_en=%b rd_addr=%0d out_valid=%b out_re=%h out_index=%0d busy=%b, required all 0",
                  rd_en, rd_addr, out_valid, out_re, out_index, busy);
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      for (int cyc = 1; cyc <= 3; cyc++) begin
         @(negedge clk);
         n_checks++;
         if (busy !== 1'b0 || rd_en !== 1'b0 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL areset_idle cyc=%0d: busy=%b rd_en=%b out_valid=%b, required 0 0 0", cyc, busy, rd_en, out_valid);
         end
      end
      $display("async reset: cleared mid-read, idle after release");
   endtask

   task automatic test_ignore_start();
      test_frame(4'd3, 3, 1'b1, 1'b1, 3);
   endtask

   task automatic test_back_to_back();
      test_frame(4'd3, 3, 1'b0, 1'b0, 0);
      test_frame(4'd2, 2, 1'b0, 1'b0, 2);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int k = 0; k < (1 << AW); k++) begin
         mem_re[k] = DW'(k);
         mem_im[k] = DW'(k) ^ 16'hC3A5;
      end
      test_reset();
      test_order();
      test_large();
      test_clamp();
      test_abort();
      test_async_reset();
      test_ignore_start();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
